// File: rtl/dlf_gear_lock_ctrl.sv
// dlf_gear_lock_ctrl: gear-shift sequencer for the type-II DLF with bang-bang PDE toggle-count lock detection
module dlf_gear_lock_ctrl #(
    parameter int CNT_W     = 16,
    parameter int WIN_LEN   = 256,
    parameter int TOG_TH    = 96,
    parameter int LOSS_TH   = 32,
    parameter int LOCK_WINS = 4
) (
    input  logic                    CKVD,
    input  logic                    NRST,
    input  logic                    EN,
    input  logic                    PDE,
    input  logic signed [5:0]       KPS_ACQ,
    input  logic signed [5:0]       KIS_ACQ,
    input  logic signed [5:0]       KPS_TRK,
    input  logic signed [5:0]       KIS_TRK,
    input  logic        [CNT_W-1:0] T_ACQ,
    input  logic        [CNT_W-1:0] T_STEP,
    output logic                    DLFEN,
    output logic signed [5:0]       KPS,
    output logic signed [5:0]       KIS,
    output logic                    IIR1EN,
    output logic                    IIR2EN,
    output logic                    DSM1STEN,
    output logic                    LOCK,
    output logic        [2:0]       STATE
);
    localparam int WW = $clog2(WIN_LEN);
    localparam int TW = $clog2(WIN_LEN + 1);
    localparam int GW = $clog2(LOCK_WINS + 1);

    typedef enum logic [2:0] {IDLE = 3'd0, ACQ = 3'd1, SHIFT = 3'd2, TRACK = 3'd3, LOCKED = 3'd4} state_t;

    state_t            state;
    logic [CNT_W-1:0]  timer, acq_end, step_end;
    logic [WW-1:0]     win_cnt;
    logic [TW-1:0]     tog_cnt, tot;
    logic [GW-1:0]     good_cnt;
    logic              pde_d, toggle, win_end, good_win, lost_win;
    logic signed [6:0] kps_dec, kis_dec;
    logic signed [5:0] kps_nx, kis_nx;

    assign STATE = state;

    // Steps are computed in 7 bits so decrementing -32 clamps instead of wrapping positive
    always_comb begin
        acq_end  = (T_ACQ == '0) ? '0 : T_ACQ - CNT_W'(1);
        step_end = (T_STEP == '0) ? '0 : T_STEP - CNT_W'(1);
        kps_dec  = $signed({KPS[5], KPS}) - 7'sd1;
        kis_dec  = $signed({KIS[5], KIS}) - 7'sd2;
        kps_nx   = (kps_dec < $signed({KPS_TRK[5], KPS_TRK})) ? KPS_TRK : kps_dec[5:0];
        kis_nx   = (kis_dec < $signed({KIS_TRK[5], KIS_TRK})) ? KIS_TRK : kis_dec[5:0];
        toggle   = PDE ^ pde_d;
        tot      = tog_cnt + TW'(toggle);
        win_end  = win_cnt == WW'(WIN_LEN - 1);
        good_win = tot >= TW'(TOG_TH);
        lost_win = tot < TW'(LOSS_TH);
    end

    always_ff @(posedge CKVD or negedge NRST) begin
        if (!NRST) begin
            state    <= IDLE;
            timer    <= '0;
            win_cnt  <= '0;
            tog_cnt  <= '0;
            good_cnt <= '0;
            pde_d    <= 1'b0;
            DLFEN    <= 1'b0;
            KPS      <= '0;
            KIS      <= '0;
            IIR1EN   <= 1'b0;
            IIR2EN   <= 1'b0;
            DSM1STEN <= 1'b0;
            LOCK     <= 1'b0;
        end else begin
            pde_d <= PDE;
            if (!EN) begin
                state    <= IDLE;
                timer    <= '0;
                win_cnt  <= '0;
                tog_cnt  <= '0;
                good_cnt <= '0;
                DLFEN    <= 1'b0;
                KPS      <= KPS_ACQ;
                KIS      <= KIS_ACQ;
                IIR1EN   <= 1'b0;
                IIR2EN   <= 1'b0;
                DSM1STEN <= 1'b0;
                LOCK     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ACQ;
                        timer <= '0;
                        DLFEN <= 1'b1;
                        KPS   <= KPS_ACQ;
                        KIS   <= KIS_ACQ;
                    end
                    ACQ: begin
                        timer <= (timer == acq_end) ? '0 : timer + CNT_W'(1);
                        if (timer == acq_end) state <= SHIFT;
                    end
                    SHIFT: begin
                        timer <= (timer == step_end) ? '0 : timer + CNT_W'(1);
                        if (timer == step_end) begin
                            KPS <= kps_nx;
                            KIS <= kis_nx;
                            if (kps_nx == KPS_TRK && kis_nx == KIS_TRK) begin
                                state    <= TRACK;
                                IIR1EN   <= 1'b1;
                                IIR2EN   <= 1'b1;
                                DSM1STEN <= 1'b1;
                                win_cnt  <= '0;
                                tog_cnt  <= '0;
                                good_cnt <= '0;
                            end
                        end
                    end
                    TRACK, LOCKED: begin
                        win_cnt <= win_end ? '0 : win_cnt + WW'(1);
                        tog_cnt <= win_end ? '0 : tot;
                        if (win_end && state == TRACK) begin
                            good_cnt <= good_win ? good_cnt + GW'(1) : '0;
                            if (good_win && good_cnt == GW'(LOCK_WINS - 1)) begin
                                state <= LOCKED;
                                LOCK  <= 1'b1;
                            end
                        end else if (win_end && lost_win) begin
                            state    <= TRACK;
                            LOCK     <= 1'b0;
                            good_cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dlf_gear_lock_ctrl.sv
// tb_dlf_gear_lock_ctrl: table-driven gear timing vectors plus directed lock/hysteresis/reset sequences
module tb_dlf_gear_lock_ctrl;
    logic              CKVD = 1'b0;
    logic              NRST, EN, PDE;
    logic signed [5:0] KPS_ACQ, KIS_ACQ, KPS_TRK, KIS_TRK;
    logic [15:0]       T_ACQ, T_STEP;
    logic              DLFEN, IIR1EN, IIR2EN, DSM1STEN, LOCK;
    logic signed [5:0] KPS, KIS;
    logic [2:0]        STATE;
    int                checks = 0;
    int                errors = 0;

    typedef struct {
        logic signed [5:0] kps_acq, kis_acq, kps_trk, kis_trk;
        logic [15:0]       t_acq, t_step;
        int                exp_shift, exp_track;
    } vec_t;

    vec_t vt[6];

    dlf_gear_lock_ctrl dut (
        .CKVD(CKVD), .NRST(NRST), .EN(EN), .PDE(PDE),
        .KPS_ACQ(KPS_ACQ), .KIS_ACQ(KIS_ACQ), .KPS_TRK(KPS_TRK), .KIS_TRK(KIS_TRK),
        .T_ACQ(T_ACQ), .T_STEP(T_STEP),
        .DLFEN(DLFEN), .KPS(KPS), .KIS(KIS), .IIR1EN(IIR1EN), .IIR2EN(IIR2EN),
        .DSM1STEN(DSM1STEN), .LOCK(LOCK), .STATE(STATE)
    );

    always #5 CKVD = ~CKVD;

    task automatic tick();
        @(posedge CKVD);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_gains(input vec_t v);
        KPS_ACQ = v.kps_acq;
        KIS_ACQ = v.kis_acq;
        KPS_TRK = v.kps_trk;
        KIS_TRK = v.kis_trk;
        T_ACQ   = v.t_acq;
        T_STEP  = v.t_step;
    endtask

    task automatic win(input int ntog);
        for (int i = 0; i < 256; i++) begin
            if (i < ntog) PDE = ~PDE;
            tick();
        end
    endtask

    initial begin
        int n;
        int exp_kps[4];
        int exp_kis[4];
        exp_kps = '{3, 2, 1, 0};
        exp_kis = '{0, -2, -4, -4};
        vt[0] = '{6'sd4,   6'sd2,   6'sd0,   -6'sd4,  16'd10, 16'd8, 11, 43};
        vt[1] = '{-6'sd30, -6'sd31, -6'sd31, -6'sd32, 16'd3,  16'd5, 4,  9};
        vt[2] = '{6'sd0,   6'sd0,   6'sd0,   6'sd0,   16'd0,  16'd0, 2,  3};
        vt[3] = '{6'sd5,   6'sd3,   6'sd1,   -6'sd3,  16'd1,  16'd2, 2,  10};
        vt[4] = '{-6'sd5,  6'sd10,  6'sd3,   6'sd0,   16'd4,  16'd3, 5,  20};
        vt[5] = '{6'sd31,  6'sd31,  -6'sd32, -6'sd32, 16'd2,  16'd1, 3,  66};

        NRST = 1'b0;
        EN   = 1'b0;
        PDE  = 1'b0;
        set_gains(vt[0]);
        #12;
        chk("rst_state", STATE, 0);
        chk("rst_kps", KPS, 0);
        chk("rst_kis", KIS, 0);
        chk("rst_dlfen", DLFEN, 0);
        chk("rst_lock", LOCK, 0);
        chk("rst_iir", {IIR1EN, IIR2EN, DSM1STEN}, 0);
        @(negedge CKVD);
        NRST = 1'b1;
        tick();
        chk("idle_state", STATE, 0);
        chk("idle_kps", KPS, 4);
        chk("idle_kis", KIS, 2);
        chk("idle_dlfen", DLFEN, 0);

        for (int k = 0; k < 6; k++) begin
            EN = 1'b0;
            set_gains(vt[k]);
            tick();
            tick();
            chk($sformatf("v%0d_idle_kps", k), KPS, vt[k].kps_acq);
            chk($sformatf("v%0d_idle_kis", k), KIS, vt[k].kis_acq);
            EN = 1'b1;
            tick();
            n = 1;
            chk($sformatf("v%0d_acq_dlfen", k), DLFEN, 1);
            while (STATE != 3'd2 && n < 200) begin tick(); n++; end
            chk($sformatf("v%0d_shift_cyc", k), n, vt[k].exp_shift);
            while (STATE != 3'd3 && n < 400) begin tick(); n++; end
            chk($sformatf("v%0d_track_cyc", k), n, vt[k].exp_track);
            chk($sformatf("v%0d_trk_kps", k), KPS, vt[k].kps_trk);
            chk($sformatf("v%0d_trk_kis", k), KIS, vt[k].kis_trk);
            chk($sformatf("v%0d_trk_en", k), {DLFEN, IIR1EN, IIR2EN, DSM1STEN}, 15);
            chk($sformatf("v%0d_trk_lock", k), LOCK, 0);
        end

        EN = 1'b0;
        set_gains(vt[0]);
        tick();
        EN = 1'b1;
        repeat (11) tick();
        chk("seq_shift_state", STATE, 2);
        chk("seq_shift_kps", KPS, 4);
        for (int s = 0; s < 4; s++) begin
            repeat (7) tick();
            chk($sformatf("seq_pre%0d_kps", s), KPS, s == 0 ? 4 : exp_kps[s-1]);
            tick();
            chk($sformatf("seq_step%0d_kps", s), KPS, exp_kps[s]);
            chk($sformatf("seq_step%0d_kis", s), KIS, exp_kis[s]);
        end
        chk("seq_track_state", STATE, 3);
        chk("seq_track_iir", {IIR1EN, IIR2EN, DSM1STEN}, 7);

        repeat (3) win(256);
        chk("lock3_lock", LOCK, 0);
        chk("lock3_state", STATE, 3);
        win(256);
        chk("lock4_lock", LOCK, 1);
        chk("lock4_state", STATE, 4);
        win(50);
        chk("hyst50_lock", LOCK, 1);
        win(32);
        chk("hyst32_lock", LOCK, 1);
        chk("hyst32_state", STATE, 4);
        win(31);
        chk("loss31_lock", LOCK, 0);
        chk("loss31_state", STATE, 3);
        repeat (3) win(96);
        win(95);
        repeat (3) win(200);
        chk("good_reset_lock", LOCK, 0);
        chk("good_reset_state", STATE, 3);
        win(96);
        chk("relock_lock", LOCK, 1);
        chk("relock_state", STATE, 4);
        PDE = 1'b1;
        tick();
        win(0);
        chk("stuck_lock", LOCK, 0);
        chk("stuck_state", STATE, 3);

        EN = 1'b0;
        tick();
        chk("drop_state", STATE, 0);
        chk("drop_en", {DLFEN, IIR1EN, IIR2EN, DSM1STEN, LOCK}, 0);
        EN = 1'b1;
        KPS_ACQ = 6'sd7;
        KIS_ACQ = -6'sd3;
        tick();
        chk("restart_state", STATE, 1);
        chk("restart_kps", KPS, 7);
        chk("restart_kis", KIS, -3);
        chk("restart_dlfen", DLFEN, 1);

        n = 0;
        while (STATE != 3'd2 && n < 200) begin tick(); n++; end
        chk("mid_shift_state", STATE, 2);
        repeat (2) tick();
        #2;
        NRST = 1'b0;
        #1;
        chk("async_state", STATE, 0);
        chk("async_kps", KPS, 0);
        chk("async_kis", KIS, 0);
        chk("async_en", {DLFEN, IIR1EN, IIR2EN, DSM1STEN, LOCK}, 0);
        #1;
        NRST = 1'b1;
        tick();
        chk("post_rst_state", STATE, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
